// File: rtl/ibex_aes_seq.sv
// Multi-cycle issue sequencer: runs NumOps chained AES byte-select ops per column request.
// Optional stall/request counters are enabled by defining IBEX_AES_SEQ_STALL_CNT_EN.
module ibex_aes_seq #(
  parameter int unsigned NumOps       = 4,
  parameter bit          LOGIC_GATING = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_mix_i,
  input  logic [31:0]  req_acc_i,
  input  logic [127:0] req_src_i,
  output logic         aes_en_o,
  output logic         aes_mix_o,
  output logic [1:0]   aes_bs_o,
  output logic [31:0]  operand_a_o,
  output logic [31:0]  operand_b_o,
  input  logic [31:0]  ex_result_i,
  input  logic         ex_valid_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [31:0]  rsp_data_o,
  output logic         busy_o
`ifdef IBEX_AES_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]  stall_cnt_o,
  output logic [15:0]  req_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  localparam logic [1:0] LastK = 2'(NumOps - 1);

  state_e           r_state;
  logic [1:0]       r_k;
  logic [31:0]      r_acc;
  logic [3:0][31:0] r_src;
  logic             r_mix;

  logic w_idle;
  logic w_issue;
  logic w_done;

  assign w_idle  = (r_state == S_IDLE);
  assign w_issue = (r_state == S_ISSUE);
  assign w_done  = (r_state == S_DONE);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
      r_acc   <= 32'd0;
      r_src   <= '0;
      r_mix   <= 1'b0;
    end else if (flush_i) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid_i) begin
            r_acc   <= req_acc_i;
            r_src   <= req_src_i;
            r_mix   <= req_mix_i;
            r_k     <= 2'd0;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ex_valid_i) begin
            r_acc <= ex_result_i;
            if (r_k == LastK) begin
              r_state <= S_DONE;
            end else begin
              r_k <= r_k + 2'd1;
            end
          end
        end
        S_DONE: begin
          if (rsp_ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_k     <= 2'd0;
        end
      endcase
    end
  end

  assign req_ready_o = w_idle && !flush_i;
  assign aes_en_o    = w_issue;
  assign aes_mix_o   = w_issue ? r_mix : 1'b0;
  assign rsp_valid_o = w_done;
  assign rsp_data_o  = w_done ? r_acc : 32'd0;
  assign busy_o      = !w_idle;

  // Gating keeps the execute-block operand buses quiet between ops.
  generate
    if (LOGIC_GATING) begin : g_gated
      assign operand_a_o = w_issue ? r_acc : 32'd0;
      assign operand_b_o = w_issue ? r_src[r_k] : 32'd0;
      assign aes_bs_o    = w_issue ? r_k : 2'd0;
    end else begin : g_ungated
      assign operand_a_o = r_acc;
      assign operand_b_o = r_src[r_k];
      assign aes_bs_o    = r_k;
    end
  endgenerate

`ifdef IBEX_AES_SEQ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_req_cnt;
  logic        w_stall;
  logic        w_rsp_hs;

  assign w_stall  = (w_issue && !ex_valid_i) || (w_done && !rsp_ready_i);
  assign w_rsp_hs = w_done && rsp_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_stall_cnt <= 16'd0;
      r_req_cnt   <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_rsp_hs && (r_req_cnt != 16'hFFFF)) begin
        r_req_cnt <= r_req_cnt + 16'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign req_cnt_o   = r_req_cnt;
`endif

endmodule
